// File: rtl/sum_display_driver.sv
// Converts the 9-bit adder result {cout, sum} to BCD with a sequential double-dabble
// engine and drives a 4-digit common-anode multiplexed display with leading-zero blanking.
module sum_display_driver #(
  parameter int DIGIT_TICKS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sum,
  input  logic        cout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [15:0] TICK_MAX  = 16'(DIGIT_TICKS - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [3:0]  LAST_ITER = 4'd8;

  logic [1:0]  state;
  logic [8:0]  v;
  logic [8:0]  last_v;
  logic [20:0] shreg;
  logic [3:0]  iter;
  logic [15:0] tick;
  logic [1:0]  idx;
  logic [6:0]  digit_seg;

  function automatic logic [3:0] adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift the whole register left.
  function automatic logic [20:0] dabble(input logic [20:0] r);
    logic [20:0] t;
    t = {adjust(r[20:17]), adjust(r[16:13]), adjust(r[12:9]), r[8:0]};
    return {t[19:0], 1'b0};
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign v    = {cout, sum};
  assign busy = (state != S_IDLE);

  // Conversion control: capture, iterate, commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      last_v <= 9'd0;
      iter   <= 4'd0;
      bcd    <= 12'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (v != last_v) begin
            last_v <= v;
            iter   <= 4'd0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          iter <= iter + 4'd1;
          if (iter == LAST_ITER) state <= S_COMMIT;
        end
        S_COMMIT: begin
          bcd   <= shreg[20:9];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shift register is pure data; it is always reloaded before use
  always_ff @(posedge clk) begin
    if (state == S_IDLE && v != last_v) shreg <= {12'd0, v};
    else if (state == S_SHIFT)          shreg <= dabble(shreg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 16'd0;
      idx  <= 2'd0;
    end else if (tick == TICK_MAX) begin
      tick <= 16'd0;
      idx  <= idx + 2'd1;
    end else begin
      tick <= tick + 16'd1;
    end
  end

  // Leading-zero blanking: tens hides only when hundreds is also zero
  always_comb begin
    digit_seg = SEG_BLANK;
    case (idx)
      2'd0: digit_seg = decode(bcd[3:0]);
      2'd1: if (bcd[11:4] != 8'd0) digit_seg = decode(bcd[7:4]);
      2'd2: if (bcd[11:8] != 4'd0) digit_seg = decode(bcd[11:8]);
      default: digit_seg = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'b1000000;
      an  <= 4'b1110;
      dp  <= 1'b1;
    end else begin
      seg <= digit_seg;
      an  <= ~(4'b0001 << idx);
      dp  <= 1'b1;
    end
  end

endmodule
